// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles, then responds.
// Optional GPIO register at MMIO_ADDR is enabled by defining DMEM_MMIO_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter              INIT_FILE   = "",
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] gpio_out
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          curWe;
  logic [31:0]   curAddr;
  logic [3:0]    curBe;
  logic [31:0]   curWdata;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          beOk, inRange, isMmio, reqErr, enterResp, memWrite;
  logic [31:0]   loadData;
  logic [31:0]   gpioVal;

  // With LATENCY==0 the response is decided on the accepting edge, so decode the live request in IDLE.
  assign curWe    = (state_q == IDLE) ? req_we    : we_q;
  assign curAddr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign curBe    = (state_q == IDLE) ? req_be    : be_q;
  assign curWdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign off      = curAddr - BASE_ADDR;
  assign idx      = off[AW+1:2];

`ifdef DMEM_MMIO_EN
  logic [31:0] gpio_q;
  assign isMmio  = (curAddr == MMIO_ADDR);
  assign gpioVal = gpio_q;
  assign gpio_out = gpio_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      gpio_q <= '0;
    else if (enterResp && isMmio && curWe && !reqErr)
      gpio_q <= curWdata;
  end
`else
  assign isMmio   = 1'b0;
  assign gpioVal  = '0;
  assign gpio_out = '0;
`endif

  always_comb begin
    beOk = 1'b0;
    case (curBe)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: beOk = 1'b1;
      4'b0011, 4'b1100:                   beOk = ~curAddr[0];
      4'b1111:                            beOk = (curAddr[1:0] == 2'b00);
      default:                            beOk = 1'b0;
    endcase
    inRange  = (curAddr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    reqErr   = isMmio ? (curBe != 4'b1111) : (!beOk || !inRange);
    loadData = '0;
    if (!reqErr && !curWe)
      loadData = isMmio ? gpioVal : mem_q[idx];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    enterResp = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d   = RESP;
            enterResp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          enterResp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rdata_d   = '0;
        err_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enterResp) begin
      rdata_d = loadData;
      err_d   = reqErr;
    end
  end

  assign memWrite  = enterResp && curWe && !reqErr && !isMmio;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset; only enabled byte lanes are updated.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (curBe[i])
          mem_q[idx][8*i +: 8] <= curWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-abort sequence
// and randomized traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] MMIO  = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] gpio_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] refMem [DEPTH];
  logic [31:0] refGpio = '0;

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT), .INIT_FILE(""), .MMIO_ADDR(MMIO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour: legality from access size and natural alignment, storage as a word array.
  task automatic modelTxn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output bit expErr, output logic [31:0] expRdata);
    longint unsigned a = longint'(addr);
    int n = $countones(be);
    bit legal;
    int unsigned w;
    expRdata = '0;
`ifdef DMEM_MMIO_EN
    if (addr == MMIO) begin
      expErr = (be != 4'hF);
      if (!expErr) begin
        if (we) refGpio = wdata;
        else expRdata = refGpio;
      end
      return;
    end
`endif
    if (n == 1) legal = 1'b1;
    else if (n == 2) legal = (be == 4'b0011 || be == 4'b1100) && (a % 2 == 0);
    else if (n == 4) legal = (a % 4 == 0);
    else legal = 1'b0;
    if (a < longint'(BASE) || a >= longint'(BASE) + 4 * longint'(DEPTH)) legal = 1'b0;
    expErr = !legal;
    if (legal) begin
      w = int'((a - longint'(BASE)) / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) refMem[w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        expRdata = refMem[w];
      end
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                               output logic [31:0] gpio, output int lat, output int busyBad,
                               output logic rspAfter, output logic readyAfter);
    lat = 0; busyBad = 0; rdata = '0; err = 1'b0; gpio = '0; rspAfter = 1'b0; readyAfter = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_be = 4'($urandom); req_wdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err; gpio = gpio_out;
        break;
      end
      if (req_ready) busyBad++;
    end
    if (lat != 0) begin
      @(negedge clk);
      rspAfter = rsp_valid;
      readyAfter = req_ready;
    end
  endtask

  task automatic runCheck(input string name, input bit we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input bit expErr, input logic [31:0] expRdata, input bit full);
    logic [31:0] rd, gp;
    logic er, ra, rr;
    int lat, bb;
    applyStimulus(we, addr, be, wdata, rd, er, gp, lat, bb, ra, rr);
    checkOutput({name, "_lat"}, 32'(lat), 32'(LAT + 1));
    checkOutput({name, "_err"}, {31'b0, er}, {31'b0, expErr});
    checkOutput({name, "_rdata"}, rd, expRdata);
    checkOutput({name, "_gpio"}, gp, refGpio);
    if (full) begin
      checkOutput({name, "_busy_ready"}, 32'(bb), 32'd0);
      checkOutput({name, "_rsp_one_cycle"}, {31'b0, ra}, 32'd0);
      checkOutput({name, "_ready_after"}, {31'b0, rr}, 32'd1);
    end
  endtask

  function automatic vec_t mkVec(string name, bit we, logic [31:0] addr, logic [3:0] be,
                                 logic [31:0] wdata, bit expErr, logic [31:0] expRdata);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
    v.expErr = expErr; v.expRdata = expRdata;
    return v;
  endfunction

  initial begin
    bit mErr;
    logic [31:0] mRd, keep;
    int sawRsp;

    vecs.push_back(mkVec("t1_store",     1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mkVec("t1_load",      0, 32'h10,   4'hF, 32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mkVec("t2_fill",      1, 32'h20,   4'hF, 32'h11223344, 0, 32'h0));
    vecs.push_back(mkVec("t2_lane2",     1, 32'h20,   4'h4, 32'h00AA0000, 0, 32'h0));
    vecs.push_back(mkVec("t2_load",      0, 32'h20,   4'hF, 32'h0,        0, 32'h11AA3344));
    vecs.push_back(mkVec("t3_misalign",  0, 32'h02,   4'hF, 32'h0,        1, 32'h0));
    vecs.push_back(mkVec("t3_fill",      1, 32'h00,   4'hF, 32'h12345678, 0, 32'h0));
    vecs.push_back(mkVec("t3_bad_be",    1, 32'h00,   4'h5, 32'hFFFFFFFF, 1, 32'h0));
    vecs.push_back(mkVec("t3_unchanged", 0, 32'h00,   4'hF, 32'h0,        0, 32'h12345678));
    vecs.push_back(mkVec("t4_top_store", 1, 32'hFFC,  4'hF, 32'hCAFEF00D, 0, 32'h0));
    vecs.push_back(mkVec("t4_top_load",  0, 32'hFFC,  4'hF, 32'h0,        0, 32'hCAFEF00D));
    vecs.push_back(mkVec("t4_past_top",  0, 32'h1000, 4'hF, 32'h0,        1, 32'h0));
    vecs.push_back(mkVec("half_hi",      1, 32'h12,   4'hC, 32'hABCD0000, 0, 32'h0));
    vecs.push_back(mkVec("half_odd",     1, 32'h13,   4'h3, 32'h00001111, 1, 32'h0));
    vecs.push_back(mkVec("be_zero",      1, 32'h10,   4'h0, 32'h55555555, 1, 32'h0));
    vecs.push_back(mkVec("byte_load",    0, 32'h11,   4'h2, 32'h0,        0, 32'hABCDBEEF));
`ifdef DMEM_MMIO_EN
    vecs.push_back(mkVec("t6_mmio_st",   1, MMIO,     4'hF, 32'h5,        0, 32'h0));
    vecs.push_back(mkVec("t6_mmio_ld",   0, MMIO,     4'hF, 32'h0,        0, 32'h5));
    vecs.push_back(mkVec("t6_mmio_byte", 1, MMIO,     4'h1, 32'h7,        1, 32'h0));
`else
    vecs.push_back(mkVec("t6_mmio_st",   1, MMIO,     4'hF, 32'h5,        1, 32'h0));
    vecs.push_back(mkVec("t6_mmio_ld",   0, MMIO,     4'hF, 32'h0,        1, 32'h0));
`endif

    // Reset state
    #12;
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_gpio", gpio_out, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Give every word the random phase may load a known value
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d = $urandom;
      modelTxn(1'b1, BASE + 32'(w * 4), 4'hF, d, mErr, mRd);
      runCheck("init", 1'b1, BASE + 32'(w * 4), 4'hF, d, mErr, mRd, 1'b0);
    end

    foreach (vecs[i]) begin
      modelTxn(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, mErr, mRd);
      runCheck(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
               vecs[i].expErr, vecs[i].expRdata, 1'b1);
    end

    // Reset during WAIT of a store: no response, no write
    keep = refMem[16];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_be = 4'hF; req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    refGpio = '0;
    #1;
    checkOutput("t5_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("t5_rdata", rsp_rdata, 32'd0);
    checkOutput("t5_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("t5_gpio", gpio_out, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("t5_ready_after", {31'b0, req_ready}, 32'd1);
    sawRsp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) sawRsp++;
    end
    checkOutput("t5_no_rsp", 32'(sawRsp), 32'd0);
    modelTxn(1'b0, 32'h40, 4'hF, 32'h0, mErr, mRd);
    checkOutput("t5_model_keep", mRd, keep);
    runCheck("t5_word_kept", 1'b0, 32'h40, 4'hF, 32'h0, mErr, mRd, 1'b1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      int r = $urandom_range(0, 9);
      logic [31:0] a;
      logic [3:0] b = 4'($urandom_range(0, 15));
      bit we = 1'($urandom);
      logic [31:0] d = $urandom;
      if (r < 8) a = BASE + 32'($urandom_range(0, 255));
      else if (r == 8) a = BASE + 32'h1000 + 32'($urandom_range(0, 255));
      else a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      modelTxn(we, a, b, d, mErr, mRd);
      runCheck("rand", we, a, b, d, mErr, mRd, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
